dsp_mul_monitor: RTL and testbench
==================================

DSP_MUL_MONITOR -- requirements
Module: dsp_mul_monitor

Interface
REQ-001 SHALL have parameter LAT, default 2, meaning the observed multiplier's pipeline latency in clk cycles (legal range 1..8).
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the pass and error counters.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  one-cycle pulse that arms the monitor and clears its counters.
REQ-006 stop  input  1  one-cycle pulse that ends operand acceptance.
REQ-007 in_valid  input  1  a/b carry an operand pair issued to the multiplier this cycle.
REQ-008 a  input  27  unsigned multiplicand.
REQ-009 b  input  18  unsigned multiplier.
REQ-010 out  input  45  product returned by the multiplier under observation.
REQ-011 busy  output  1  high in RUN or DRAIN.
REQ-012 done  output  1  high in DONE.
REQ-013 chk_valid  output  1  one-cycle pulse when a comparison is made.
REQ-014 mismatch  output  1  qualified by chk_valid; high when out differs from expected.
REQ-015 exp_out  output  45  expected product for the current comparison.
REQ-016 pass_cnt, err_cnt  output  CNT_W each  comparison counters.
REQ-017 first_a/first_b/first_out/first_vld  output  27/18/45/1  first-mismatch capture.

Function
REQ-018 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-019 Transitions SHALL be: IDLE->RUN on start; RUN->DRAIN on stop; DRAIN->DONE when the delay line holds no valid entry; DONE->RUN on start.
REQ-020 start SHALL be ignored in RUN and DRAIN, and stop SHALL be ignored in IDLE, DRAIN and DONE; start with stop in IDLE/DONE SHALL enter RUN.
REQ-021 An operand pair SHALL be accepted only when in_valid=1 in RUN, including the cycle stop is sampled; in_valid in any other state SHALL be dropped.
REQ-022 Expected product SHALL be the full-width unsigned a*b (45 bits, no truncation), carried with a valid bit through a LAT-stage delay line.
REQ-023 A pair accepted at edge t SHALL be compared against out sampled at edge t+LAT, asserting chk_valid with that comparison's mismatch and exp_out in the cycle after edge t+LAT.
REQ-024 Back-to-back in_valid SHALL be sustained at one comparison per cycle with no bubbles.
REQ-025 Each comparison SHALL increment pass_cnt (match) or err_cnt (mismatch), each saturating at all-ones without wrapping.
REQ-026 start SHALL clear counters, first_vld and the delay line in the same edge that enters RUN.
REQ-027 DRAIN SHALL finish in-flight comparisons, and DRAIN->DONE SHALL take exactly LAT cycles after the last accepted pair, or 1 cycle if none are in flight.
REQ-028 Counters and capture SHALL hold their values in DONE until the next start.

Reset
REQ-029 rst SHALL force IDLE and drive busy, done, chk_valid, mismatch, first_vld to 0 and exp_out, counters and first_* to 0 asynchronously.
REQ-030 rst mid-RUN or mid-DRAIN SHALL discard all in-flight entries with no chk_valid after release.
REQ-031 The first edge after rst deasserts SHALL act as normal operation.

Configuration
REQ-032 With macro MON_CAPTURE_EN defined, the first mismatch after start SHALL latch a, b, out into first_a/first_b/first_out and set first_vld, ignoring later mismatches.
REQ-033 Without MON_CAPTURE_EN, first_* ports SHALL exist and be tied to 0, with no capture registers built.

Verification
REQ-034 Reset then start; a=27'h7ffffff, b=18'h3ffff, correct out after LAT=2 -> chk_valid, exp_out=45'h1ffff7fc0001, mismatch=0, pass_cnt=1.
REQ-035 Four back-to-back pairs (7ffffff/3ffff, 3ffffff/1ffff, 3ffffff/3ffff, 7ffffff/1ffff), correct outs -> 4 consecutive chk_valid, pass_cnt=4, err_cnt=0.
REQ-036 Second pair's out corrupted by bit0 flip -> mismatch on the 2nd check only, err_cnt=1, and with MON_CAPTURE_EN first_a=27'h3ffffff, first_b=18'h1ffff, first_vld=1.
REQ-037 stop issued with 2 pairs in flight -> both still checked, then done=1 exactly LAT cycles after the last accept, and in_valid during DRAIN is not counted.
REQ-038 rst asserted mid-RUN with pairs in flight -> all outputs 0 immediately, and no chk_valid after release.
REQ-039 CNT_W=4 with 20 matching pairs -> pass_cnt holds 4'hf.

Source files
------------

// File: rtl/dsp_mul_monitor.sv
// dsp_mul_monitor: checks a pipelined 27x18 unsigned multiplier against a
// reference product. The reference travels through a LAT-deep delay line so
// that it lines up with the multiplier's result.
// Optional build macro: MON_CAPTURE_EN records the operands and the returned
// value of the first mismatch after each start.
module dsp_mul_monitor #(
    parameter int LAT   = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             in_valid,
    input  logic [26:0]      a,
    input  logic [17:0]      b,
    input  logic [44:0]      out,
    output logic             busy,
    output logic             done,
    output logic             chk_valid,
    output logic             mismatch,
    output logic [44:0]      exp_out,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [26:0]      first_a,
    output logic [17:0]      first_b,
    output logic [44:0]      first_out,
    output logic             first_vld
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]   state;
    logic [1:0]   state_nxt;
    logic         arm;
    logic         accept;
    logic         pending;
    logic         cmp;
    logic         ne;
    logic [44:0]  prod_in;

    logic [LAT-1:0] vld;
    logic [44:0]    prod [LAT];

    // A new run may only be armed from an idle or finished monitor.
    assign arm     = start && (state == S_IDLE || state == S_DONE);
    assign accept  = in_valid && (state == S_RUN);
    assign prod_in = 45'(a) * 45'(b);
    assign cmp     = vld[LAT-1];
    assign ne      = (out != prod[LAT-1]);
    assign busy    = (state == S_RUN) || (state == S_DRAIN);
    assign done    = (state == S_DONE);

    // Look for entries that will still be in flight after the next shift;
    // the last stage is being compared this cycle, so it does not count.
    always_comb begin
        // NOTE: give every always_comb output a default first so that no
        // path leaves it unassigned, which would infer a latch.
        pending = 1'b0;
        for (int i = 0; i < LAT - 1; i++) begin
            pending = pending | vld[i];
        end
    end

    // Next-state selection for the run/drain/done sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start)    state_nxt = S_RUN;
            S_RUN:          if (stop)     state_nxt = S_DRAIN;
            S_DRAIN:        if (!pending) state_nxt = S_DONE;
            default:                      state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Valid bits of the delay line; cleared when a run is armed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
        end else if (arm) begin
            vld <= '0;
        end else begin
            vld[0] <= accept;
            for (int i = 1; i < LAT; i++) begin
                vld[i] <= vld[i-1];
            end
        end
    end

`ifdef MON_CAPTURE_EN
    logic [26:0] line_a [LAT];
    logic [17:0] line_b [LAT];
`endif

    // Payload of the delay line: expected product (and operands if capture
    // is built), shifted every cycle.
    always_ff @(posedge clk) begin
        // NOTE: payload registers are deliberately not reset; they are only
        // looked at when the matching valid bit is set, and that bit is reset.
        prod[0] <= prod_in;
        for (int i = 1; i < LAT; i++) begin
            prod[i] <= prod[i-1];
        end
`ifdef MON_CAPTURE_EN
        line_a[0] <= a;
        line_b[0] <= b;
        for (int i = 1; i < LAT; i++) begin
            line_a[i] <= line_a[i-1];
            line_b[i] <= line_b[i-1];
        end
`endif
    end

    // Comparison result, presented for one cycle; exp_out holds between checks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_valid <= 1'b0;
            mismatch  <= 1'b0;
            exp_out   <= '0;
        end else begin
            chk_valid <= cmp;
            mismatch  <= cmp && ne;
            if (cmp) begin
                exp_out <= prod[LAT-1];
            end
        end
    end

    // Saturating pass/error counters, cleared on arm.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_cnt <= '0;
            err_cnt  <= '0;
        end else if (arm) begin
            pass_cnt <= '0;
            err_cnt  <= '0;
        end else if (cmp) begin
            if (ne) begin
                if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
            end else begin
                if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
            end
        end
    end

`ifdef MON_CAPTURE_EN
    // First-mismatch capture; later mismatches are ignored until re-armed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_vld <= 1'b0;
            first_a   <= '0;
            first_b   <= '0;
            first_out <= '0;
        end else if (arm) begin
            first_vld <= 1'b0;
            first_a   <= '0;
            first_b   <= '0;
            first_out <= '0;
        end else if (cmp && ne && !first_vld) begin
            first_vld <= 1'b1;
            first_a   <= line_a[LAT-1];
            first_b   <= line_b[LAT-1];
            first_out <= out;
        end
    end
`else
    assign first_vld = 1'b0;
    assign first_a   = '0;
    assign first_b   = '0;
    assign first_out = '0;
`endif

endmodule

// File: tb/tb_dsp_mul_monitor.sv
// Self-checking bench for dsp_mul_monitor: directed vectors for the named
// scenarios plus a randomized run against a cycle-indexed reference model.
module tb_dsp_mul_monitor;

    localparam int LAT = 2;
    localparam int HN  = 4096;
`ifdef MON_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stop, in_valid;
    logic [26:0] a;
    logic [17:0] b;
    logic [44:0] out;

    logic        busy, done, chk_valid, mismatch, first_vld;
    logic [44:0] exp_out, first_out;
    logic [15:0] pass_cnt, err_cnt;
    logic [26:0] first_a;
    logic [17:0] first_b;

    logic        busy4, done4, chk_valid4, mismatch4, first_vld4;
    logic [44:0] exp_out4, first_out4;
    logic [3:0]  pass_cnt4, err_cnt4;
    logic [26:0] first_a4;
    logic [17:0] first_b4;

    always #5 clk = ~clk;

    dsp_mul_monitor #(.LAT(LAT), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid),
        .a(a), .b(b), .out(out), .busy(busy), .done(done), .chk_valid(chk_valid),
        .mismatch(mismatch), .exp_out(exp_out), .pass_cnt(pass_cnt), .err_cnt(err_cnt),
        .first_a(first_a), .first_b(first_b), .first_out(first_out), .first_vld(first_vld)
    );

    dsp_mul_monitor #(.LAT(LAT), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid),
        .a(a), .b(b), .out(out), .busy(busy4), .done(done4), .chk_valid(chk_valid4),
        .mismatch(mismatch4), .exp_out(exp_out4), .pass_cnt(pass_cnt4), .err_cnt(err_cnt4),
        .first_a(first_a4), .first_b(first_b4), .first_out(first_out4), .first_vld(first_vld4)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: every issued pair is recorded by edge index; a pair
    // issued at edge j is judged at edge j+LAT.
    typedef enum {M_IDLE, M_RUN, M_DRAIN, M_DONE} mode_t;
    mode_t       mode;
    int          cyc = 0;
    int          epoch = 0;
    int          last_acc = -100;
    bit          acc_h [HN];
    bit          cor_h [HN];
    logic [44:0] prod_h [HN];
    logic [26:0] a_h [HN];
    logic [17:0] b_h [HN];
    int          m_pass, m_err;
    bit          m_chk, m_mis, m_fvld;
    logic [44:0] m_exp, m_fout;
    logic [26:0] m_fa;
    logic [17:0] m_fb;

    logic [44:0] seen_exp [$];
    int          seen_cyc [$];
    bit          seen_mis [$];

    function automatic longint sat(input int v, input int w);
        longint mx = (64'd1 << w) - 1;
        return (v > mx) ? mx : longint'(v);
    endfunction

    task automatic model_clear();
        m_pass = 0; m_err = 0; m_fvld = 0; m_fa = '0; m_fb = '0; m_fout = '0;
    endtask

    task automatic step(input bit st, input bit sp, input bit iv,
                        input logic [26:0] aa, input logic [17:0] bb, input bit cor);
        int j;
        bit acc, chk;
        j = cyc - LAT;
        start = st; stop = sp; in_valid = iv; a = aa; b = bb;
        if (j >= epoch && acc_h[j]) out = prod_h[j] ^ 45'(cor_h[j]);
        else                        out = 45'({$urandom, $urandom});
        @(posedge clk);
        chk = (j >= epoch) && acc_h[j];
        acc = (mode == M_RUN) && iv;
        acc_h[cyc] = acc; cor_h[cyc] = cor; prod_h[cyc] = 45'(aa) * 45'(bb);
        a_h[cyc] = aa; b_h[cyc] = bb;
        if (acc) last_acc = cyc;
        m_chk = chk;
        m_mis = chk && cor_h[j];
        if (chk) begin
            m_exp = prod_h[j];
            if (cor_h[j]) begin
                m_err++;
                if (CAP && !m_fvld) begin
                    m_fvld = 1; m_fa = a_h[j]; m_fb = b_h[j]; m_fout = out;
                end
            end else begin
                m_pass++;
            end
        end
        case (mode)
            M_IDLE, M_DONE: if (st) begin mode = M_RUN; epoch = cyc; model_clear(); end
            M_RUN:          if (sp) mode = M_DRAIN;
            M_DRAIN:        if (last_acc < epoch || last_acc + LAT <= cyc) mode = M_DONE;
            default:        mode = M_IDLE;
        endcase
        cyc++;
        @(negedge clk);
        check("chk_valid", chk_valid, m_chk);
        check("mismatch", mismatch, m_mis);
        check("exp_out", exp_out, m_exp);
        check("busy", busy, (mode == M_RUN || mode == M_DRAIN));
        check("done", done, (mode == M_DONE));
        check("pass_cnt", pass_cnt, sat(m_pass, 16));
        check("err_cnt", err_cnt, sat(m_err, 16));
        check("pass_cnt4", pass_cnt4, sat(m_pass, 4));
        check("err_cnt4", err_cnt4, sat(m_err, 4));
        check("first_vld", first_vld, m_fvld);
        check("first_a", first_a, m_fa);
        check("first_b", first_b, m_fb);
        check("first_out", first_out, m_fout);
        if (chk_valid) begin
            seen_exp.push_back(exp_out);
            seen_cyc.push_back(cyc);
            seen_mis.push_back(mismatch);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, '0, '0, 0);
    endtask

    task automatic drain_wait();
        for (int k = 0; k < 20 && !done; k++) step(0, 0, 0, '0, '0, 0);
        check("drain_reaches_done", done, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 0; stop = 0; in_valid = 0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_chk_valid", chk_valid, 0);
        check("rst_mismatch", mismatch, 0);
        check("rst_exp_out", exp_out, 0);
        check("rst_pass_cnt", pass_cnt, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_first_vld", first_vld, 0);
        check("rst_first_a", first_a, 0);
        check("rst_first_out", first_out, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mode = M_IDLE; epoch = cyc; model_clear();
        m_exp = '0; m_chk = 0; m_mis = 0;
    endtask

    typedef struct {
        logic [26:0] a;
        logic [17:0] b;
        bit          cor;
        logic [44:0] exp;
    } vec_t;
    vec_t tbl [4];

    task automatic run_table(input int bad_idx);
        step(1, 0, 0, '0, '0, 0);
        seen_exp.delete(); seen_cyc.delete(); seen_mis.delete();
        for (int i = 0; i < 4; i++) step(0, i == 3, 1, tbl[i].a, tbl[i].b, i == bad_idx);
        drain_wait();
        check("tbl_count", seen_exp.size(), 4);
        for (int i = 0; i < 4 && i < seen_exp.size(); i++) begin
            check($sformatf("tbl_exp[%0d]", i), seen_exp[i], tbl[i].exp);
            check($sformatf("tbl_back2back[%0d]", i), seen_cyc[i], seen_cyc[0] + i);
            check($sformatf("tbl_mis[%0d]", i), seen_mis[i], i == bad_idx);
        end
    endtask

    initial begin
        int k;
        tbl[0] = '{27'h7ffffff, 18'h3ffff, 1'b0, 45'h1ffff7fc0001};
        tbl[1] = '{27'h3ffffff, 18'h1ffff, 1'b0, 45'h007fffbfe0001};
        tbl[2] = '{27'h3ffffff, 18'h3ffff, 1'b0, 45'h00ffffbfc0001};
        tbl[3] = '{27'h7ffffff, 18'h1ffff, 1'b0, 45'h00ffff7fe0001};
        rst = 1'b1; start = 0; stop = 0; in_valid = 0; a = '0; b = '0; out = '0;
        mode = M_IDLE; model_clear(); m_exp = '0; m_chk = 0; m_mis = 0;
        @(negedge clk);
        do_reset();
        idle(2);

        // Single full-scale product.
        step(1, 0, 0, '0, '0, 0);
        step(0, 0, 1, 27'h7ffffff, 18'h3ffff, 0);
        idle(3);
        check("single_exp_out", exp_out, 45'h1ffff7fc0001);
        check("single_pass", pass_cnt, 1);
        step(0, 1, 0, '0, '0, 0);
        drain_wait();

        // Back-to-back vectors, then the same with the 2nd result corrupted.
        run_table(-1);
        check("tbl_pass", pass_cnt, 4);
        check("tbl_err", err_cnt, 0);
        run_table(1);
        check("tbl_bad_pass", pass_cnt, 3);
        check("tbl_bad_err", err_cnt, 1);
`ifdef MON_CAPTURE_EN
        check("cap_first_a", first_a, 27'h3ffffff);
        check("cap_first_b", first_b, 18'h1ffff);
        check("cap_first_vld", first_vld, 1);
`else
        check("nocap_first_vld", first_vld, 0);
`endif

        // Stop with two pairs in flight; in_valid during drain is dropped.
        step(1, 0, 0, '0, '0, 0);
        step(0, 0, 1, 27'h1234567, 18'h2abcd, 0);
        step(0, 1, 1, 27'h0fedcba, 18'h15555, 0);
        k = 0;
        while (!done && k < 20) begin
            step(0, 0, 1, 27'h5, 18'h7, 0);
            k++;
        end
        check("drain_latency", k, LAT);
        check("drain_pass", pass_cnt, 2);
        idle(3);
        check("drain_no_extra", pass_cnt, 2);

        // Randomized traffic, including stray start/stop pulses.
        step(1, 0, 0, '0, '0, 0);
        for (int i = 0; i < 500; i++) begin
            step(($urandom % 40) == 0, ($urandom % 30) == 0, ($urandom % 4) != 0,
                 27'($urandom), 18'($urandom), ($urandom % 8) == 0);
        end
        step(0, 1, 0, '0, '0, 0);
        drain_wait();

        // Reset in the middle of a run with pairs in flight.
        step(1, 0, 0, '0, '0, 0);
        step(0, 0, 1, 27'h111, 18'h222, 0);
        step(0, 0, 1, 27'h333, 18'h444, 0);
        do_reset();
        seen_exp.delete();
        idle(5);
        check("post_rst_no_chk", seen_exp.size(), 0);

        // Saturation of the narrow counter.
        step(1, 0, 0, '0, '0, 0);
        for (int i = 0; i < 20; i++) step(0, i == 19, 1, 27'($urandom), 18'($urandom), 0);
        drain_wait();
        check("sat_pass4", pass_cnt4, 4'hf);
        check("sat_pass16", pass_cnt, 20);
        idle(2);
        check("done_hold_pass4", pass_cnt4, 4'hf);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
